// File: rtl/bpi_flash_responder_pkg.sv
// Shared constants and types for the BPI NOR flash responder: command bytes,
// status-register bit positions, read modes and controller states.
package bpi_flash_responder_pkg;

    // Command bytes, decoded from the low byte of a committed bus write
    localparam logic [7:0] CMD_READ_ARRAY    = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS   = 8'h70;
    localparam logic [7:0] CMD_READ_ID       = 8'h90;
    localparam logic [7:0] CMD_CLEAR_STATUS  = 8'h50;
    localparam logic [7:0] CMD_PROGRAM       = 8'h40;
    localparam logic [7:0] CMD_PROGRAM_ALT   = 8'h10;
    localparam logic [7:0] CMD_ERASE_SETUP   = 8'h20;
    localparam logic [7:0] CMD_ERASE_CONFIRM = 8'hD0;

    // Status register bit positions
    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;

    typedef enum logic [1:0] {
        MODE_ARRAY  = 2'd0,
        MODE_STATUS = 2'd1,
        MODE_ID     = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_READY       = 3'd0,
        ST_PROG_SETUP  = 3'd1,
        ST_PROG_READ   = 3'd2,
        ST_PROG_WRITE  = 3'd3,
        ST_PROG_WAIT   = 3'd4,
        ST_ERASE_SETUP = 3'd5,
        ST_ERASE       = 3'd6
    } state_t;

endpackage

// File: rtl/bpi_flash_responder_sync_ff.sv
// Multi-stage synchronizer bringing the asynchronous BPI pins into clk.
module sync_ff #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the pin values through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is a short flop chain, not a RAM, so resetting
            // every entry is cheap and keeps the strobes inactive out of reset.
            for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its predecessor held before the edge; blocking ones would
            // collapse the chain into a single flop.
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/bpi_flash_responder.sv
// BPI NOR flash device model answering the asynchronous CE#/OE#/WE# bus with
// a P30 command subset, backed by an external single-port RAM.
module bpi_flash_responder
    import bpi_flash_responder_pkg::*;
#(
    parameter int          C_MEM_WIDTH      = 16,
    parameter int          C_ADDR_WIDTH     = 26,
    parameter int          C_BLOCK_WORDS    = 65536,
    parameter int          C_PROGRAM_CYCLES = 16,
    parameter int          C_SYNC_STAGES    = 2,
    parameter logic [15:0] C_MANUF_ID       = 16'h0089,
    parameter logic [15:0] C_DEVICE_ID      = 16'h8960
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_ADDR_WIDTH-1:0] bpi_a,
    input  logic [C_MEM_WIDTH-1:0]  bpi_dq_i,
    output logic [C_MEM_WIDTH-1:0]  bpi_dq_o,
    output logic                    bpi_dq_t,
    input  logic                    bpi_adv,
    input  logic                    bpi_ce_n,
    input  logic                    bpi_oe_n,
    input  logic                    bpi_we_n,
    output logic [C_ADDR_WIDTH-1:0] mem_addr,
    output logic [C_MEM_WIDTH-1:0]  mem_wdata,
    output logic                    mem_we,
    input  logic [C_MEM_WIDTH-1:0]  mem_rdata,
    output logic                    busy
);

    localparam int OFS_W = $clog2(C_BLOCK_WORDS);
    localparam int BLK_W = C_ADDR_WIDTH - OFS_W;
    localparam int CNT_W = $clog2(C_PROGRAM_CYCLES + 1);

    // Synchronized pins
    logic [2:0]                           strobe_s;
    logic [C_ADDR_WIDTH+C_MEM_WIDTH-1:0]  bus_s;
    logic [C_ADDR_WIDTH-1:0]              a_s;
    logic [C_MEM_WIDTH-1:0]               dq_s;
    logic                                 ce_s, oe_s, we_s;

    // Bus write capture and commit detection
    logic                    we_prev;
    logic                    commit;
    logic [C_ADDR_WIDTH-1:0] cap_addr;
    logic [C_MEM_WIDTH-1:0]  cap_data;

    // Controller state
    state_t                  state;
    mode_t                   mode;
    logic                    sr_ready, sr_erase_err, sr_prog_err;
    logic [7:0]              sr;
    logic [C_ADDR_WIDTH-1:0] prog_addr;
    logic [C_MEM_WIDTH-1:0]  prog_data;
    logic [CNT_W-1:0]        wait_cnt;
    logic [BLK_W-1:0]        erase_blk;
    logic [OFS_W-1:0]        erase_cnt;
    logic [C_MEM_WIDTH-1:0]  read_word;
    logic                    unused;

    // Only asynchronous mode is modelled, so ADV# has no effect
    assign unused = bpi_adv;

    sync_ff #(
        .WIDTH     (3),
        .STAGES    (C_SYNC_STAGES),
        .RESET_VAL (3'b111)
    ) u_sync_strobe (
        .clk (clk),
        .rst (rst),
        .d   ({bpi_ce_n, bpi_oe_n, bpi_we_n}),
        .q   (strobe_s)
    );

    sync_ff #(
        .WIDTH     (C_ADDR_WIDTH + C_MEM_WIDTH),
        .STAGES    (C_SYNC_STAGES),
        .RESET_VAL ('0)
    ) u_sync_bus (
        .clk (clk),
        .rst (rst),
        .d   ({bpi_a, bpi_dq_i}),
        .q   (bus_s)
    );

    assign {ce_s, oe_s, we_s} = strobe_s;
    assign {a_s, dq_s}        = bus_s;
    assign commit             = !ce_s && we_s && !we_prev;
    assign busy               = !sr_ready;

    // Latch address and data while the host holds CE# and WE# low
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if (!ce_s && !we_s) begin
            cap_addr <= a_s;
            cap_data <= dq_s;
        end
    end

    // Command interpreter, program sequencer and block-erase sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_READY;
            mode         <= MODE_ARRAY;
            sr_ready     <= 1'b1;
            sr_erase_err <= 1'b0;
            sr_prog_err  <= 1'b0;
            we_prev      <= 1'b1;
            prog_addr    <= '0;
            prog_data    <= '0;
            wait_cnt     <= '0;
            erase_blk    <= '0;
            erase_cnt    <= '0;
        end else begin
            we_prev <= we_s;
            case (state)
                ST_READY: begin
                    if (commit) begin
                        case (cap_data[7:0])
                            CMD_READ_ARRAY:   mode <= MODE_ARRAY;
                            CMD_READ_STATUS:  mode <= MODE_STATUS;
                            CMD_READ_ID:      mode <= MODE_ID;
                            CMD_CLEAR_STATUS: begin
                                sr_erase_err <= 1'b0;
                                sr_prog_err  <= 1'b0;
                            end
                            CMD_PROGRAM, CMD_PROGRAM_ALT: state <= ST_PROG_SETUP;
                            CMD_ERASE_SETUP:  state <= ST_ERASE_SETUP;
                            default: ;
                        endcase
                    end
                end
                ST_PROG_SETUP: begin
                    if (commit) begin
                        prog_addr <= cap_addr;
                        prog_data <= cap_data;
                        mode      <= MODE_STATUS;
                        sr_ready  <= 1'b0;
                        state     <= ST_PROG_READ;
                    end
                end
                ST_PROG_READ: state <= ST_PROG_WRITE;
                ST_PROG_WRITE: begin
                    // Flash can only clear bits; a 0->1 request is an error
                    if ((mem_rdata & prog_data) != prog_data) sr_prog_err <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_PROG_WAIT;
                end
                ST_PROG_WAIT: begin
                    if (wait_cnt == CNT_W'(C_PROGRAM_CYCLES - 1)) begin
                        sr_ready <= 1'b1;
                        state    <= ST_READY;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ERASE_SETUP: begin
                    if (commit) begin
                        mode <= MODE_STATUS;
                        if (cap_data[7:0] == CMD_ERASE_CONFIRM) begin
                            erase_blk <= cap_addr[C_ADDR_WIDTH-1:OFS_W];
                            erase_cnt <= '0;
                            sr_ready  <= 1'b0;
                            state     <= ST_ERASE;
                        end else begin
                            sr_erase_err <= 1'b1;
                            sr_prog_err  <= 1'b1;
                            state        <= ST_READY;
                        end
                    end
                end
                ST_ERASE: begin
                    // The offset counter is block-sized, so it wraps instead
                    // of carrying into the block index
                    erase_cnt <= erase_cnt + 1'b1;
                    if (erase_cnt == '1) begin
                        sr_ready <= 1'b1;
                        state    <= ST_READY;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

    // Assemble the status register from its live bits
    always_comb begin
        sr               = '0;
        sr[SR_READY]     = sr_ready;
        sr[SR_ERASE_ERR] = sr_erase_err;
        sr[SR_PROG_ERR]  = sr_prog_err;
    end

    // RAM port: the sequencers own it while programming or erasing
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        mem_addr  = a_s;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_PROG_READ:  mem_addr = prog_addr;
            ST_PROG_WRITE: begin
                mem_addr  = prog_addr;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata & prog_data;
            end
            ST_ERASE: begin
                mem_addr  = {erase_blk, erase_cnt};
                mem_we    = 1'b1;
                mem_wdata = '1;
            end
            default: ;
        endcase
    end

    // Select the word the host sees; status wins while an operation runs
    always_comb begin
        read_word = mem_rdata;
        if (!sr_ready || mode == MODE_STATUS) begin
            read_word = C_MEM_WIDTH'(sr);
        end else if (mode == MODE_ID) begin
            if (a_s[OFS_W-1:0] == OFS_W'(0))      read_word = C_MEM_WIDTH'(C_MANUF_ID);
            else if (a_s[OFS_W-1:0] == OFS_W'(1)) read_word = C_MEM_WIDTH'(C_DEVICE_ID);
            else                                  read_word = '0;
        end
    end

    // Registered data and output-enable toward the pins
    always_ff @(posedge clk) begin
        if (rst) begin
            bpi_dq_t <= 1'b1;
            bpi_dq_o <= '0;
        end else begin
            bpi_dq_t <= !(!ce_s && !oe_s && we_s);
            bpi_dq_o <= read_word;
        end
    end

endmodule

// File: tb/tb_bpi_flash_responder.sv
// Self-checking bench for bpi_flash_responder: pin-level host tasks, a
// one-cycle-latency RAM, and a command-level reference model of the flash.
module tb_bpi_flash_responder;

    localparam int AW    = 8;
    localparam int BW    = 16;
    localparam int PC    = 16;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] bpi_a;
    logic [15:0]   bpi_dq_i, bpi_dq_o;
    logic          bpi_dq_t, bpi_adv, bpi_ce_n, bpi_oe_n, bpi_we_n;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic          mem_we, busy;

    always #5 clk = ~clk;

    bpi_flash_responder #(
        .C_MEM_WIDTH      (16),
        .C_ADDR_WIDTH     (AW),
        .C_BLOCK_WORDS    (BW),
        .C_PROGRAM_CYCLES (PC),
        .C_SYNC_STAGES    (2),
        .C_MANUF_ID       (16'h0089),
        .C_DEVICE_ID      (16'h8960)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bpi_a     (bpi_a),
        .bpi_dq_i  (bpi_dq_i),
        .bpi_dq_o  (bpi_dq_o),
        .bpi_dq_t  (bpi_dq_t),
        .bpi_adv   (bpi_adv),
        .bpi_ce_n  (bpi_ce_n),
        .bpi_oe_n  (bpi_oe_n),
        .bpi_we_n  (bpi_we_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Backing RAM with a backdoor preload port
    logic [15:0]   ram [WORDS];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [15:0]   bd_data;

    always @(posedge clk) begin
        if (bd_we)       ram[bd_addr]  <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Count cycles with busy high and with RAM writes
    int busy_total = 0;
    int we_total   = 0;
    always @(posedge clk) begin
        if (busy)   busy_total++;
        if (mem_we) we_total++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [WORDS];
    logic [7:0]  ref_sr;
    int          ref_mode;  // 0 array, 1 status, 2 id
    int          pend;      // 0 none, 1 program data next, 2 erase confirm next

    function automatic logic [15:0] model_read(input logic [AW-1:0] a);
        if (ref_mode == 1) return {8'h00, ref_sr};
        if (ref_mode == 2) begin
            case (int'(a) % BW)
                0:       return 16'h0089;
                1:       return 16'h8960;
                default: return 16'h0000;
            endcase
        end
        return ref_mem[a];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [15:0] d,
                               output int busy_cycles);
        logic [15:0] old;
        int base;
        busy_cycles = 0;
        if (pend == 1) begin
            old        = ref_mem[a];
            ref_mem[a] = old & d;
            if ((old & d) != d) ref_sr = ref_sr | 8'h10;
            ref_mode    = 1;
            pend        = 0;
            busy_cycles = PC + 2;
        end else if (pend == 2) begin
            pend     = 0;
            ref_mode = 1;
            if (d[7:0] == 8'hD0) begin
                base = (int'(a) / BW) * BW;
                for (int i = 0; i < BW; i++) ref_mem[base + i] = 16'hFFFF;
                busy_cycles = BW;
            end else begin
                ref_sr = ref_sr | 8'h30;
            end
        end else begin
            case (d[7:0])
                8'hFF:        ref_mode = 0;
                8'h70:        ref_mode = 1;
                8'h90:        ref_mode = 2;
                8'h50:        ref_sr = ref_sr & 8'hCF;
                8'h40, 8'h10: pend = 1;
                8'h20:        pend = 2;
                default: ;
            endcase
        end
    endtask

    // ---------------- host bus tasks ----------------
    task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        bpi_a    = a;
        bpi_dq_i = d;
        bpi_ce_n = 1'b0;
        bpi_we_n = 1'b0;
        repeat (4) @(negedge clk);
        bpi_we_n = 1'b1;
        repeat (4) @(negedge clk);
        bpi_ce_n = 1'b1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [15:0] d, output logic t);
        @(negedge clk);
        bpi_a    = a;
        bpi_ce_n = 1'b0;
        bpi_oe_n = 1'b0;
        repeat (6) @(negedge clk);
        d        = bpi_dq_o;
        t        = bpi_dq_t;
        bpi_oe_n = 1'b1;
        bpi_ce_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Write through the bus, update the model, wait out any busy period
    task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d,
                              input string tag, output int busy_seen);
        int exp_busy, b0, n;
        b0 = busy_total;
        bus_write(a, d);
        model_write(a, d, exp_busy);
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        busy_seen = busy_total - b0;
        check({tag, "_busy_len"}, busy_seen, exp_busy);
    endtask

    task automatic host_read(input logic [AW-1:0] a, input string tag);
        logic [15:0] d;
        logic        t;
        bus_read(a, d, t);
        check(tag, d, model_read(a));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] d, w1f, w30;
        logic        t;
        int          bs, we0, bad, op;
        logic [AW-1:0] ra;

        bpi_a = '0; bpi_dq_i = '0; bpi_adv = 1'b0;
        bpi_ce_n = 1'b1; bpi_oe_n = 1'b1; bpi_we_n = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = 16'($urandom);
        ref_mem[8'h10] = 16'h1234;
        ref_mem[8'h40] = 16'hFFFF;
        ref_mem[8'h41] = 16'h00FF;
        ref_sr = 8'h80; ref_mode = 0; pend = 0;

        // Preload the RAM while the DUT is held in reset
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = ref_mem[i];
        end
        @(negedge clk);
        bd_we = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_dq_t", bpi_dq_t, 1'b1);
        check("rst_dq_o", bpi_dq_o, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 16'h0000);

        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Array read
        bus_read(8'h10, d, t);
        check("read_array", d, 16'h1234);
        check("dq_t_during_read", t, 1'b0);
        check("dq_t_after_read", bpi_dq_t, 1'b1);

        // Program into an erased word
        host_write(8'h00, 16'h0040, "prog1_setup", bs);
        host_write(8'h40, 16'h00F0, "prog1_data", bs);
        check("prog1_busy_18", bs, 18);
        check("prog1_ram", ram[8'h40], 16'h00F0);
        bus_read(8'h40, d, t);
        check("prog1_status", d, 16'h0080);

        // Program that tries to set bits
        host_write(8'h00, 16'h0010, "prog2_setup", bs);
        host_write(8'h41, 16'h0F0F, "prog2_data", bs);
        check("prog2_ram", ram[8'h41], 16'h000F);
        bus_read(8'h41, d, t);
        check("prog2_status_err", d, 16'h0090);
        host_write(8'h00, 16'h0050, "clear1", bs);
        bus_read(8'h41, d, t);
        check("prog2_status_clr", d, 16'h0080);

        // Block erase
        w1f = ram[8'h1F];
        w30 = ram[8'h30];
        host_write(8'h23, 16'h0020, "erase_setup", bs);
        host_write(8'h23, 16'h00D0, "erase_confirm", bs);
        check("erase_busy_16", bs, 16);
        bad = 0;
        for (int i = 8'h20; i <= 8'h2F; i++) if (ram[i] !== 16'hFFFF) bad++;
        check("erase_block_words", bad, 0);
        check("erase_below_block", ram[8'h1F], w1f);
        check("erase_above_block", ram[8'h30], w30);

        // Erase sequence error
        we0 = we_total;
        host_write(8'h50, 16'h0020, "eseq_setup", bs);
        host_write(8'h50, 16'h00FF, "eseq_bad", bs);
        bus_read(8'h50, d, t);
        check("eseq_status", d, 16'h00B0);
        check("eseq_no_writes", we_total - we0, 0);
        host_write(8'h00, 16'h0050, "clear2", bs);

        // Read ID then back to array
        host_write(8'h00, 16'h0090, "read_id", bs);
        bus_read(8'h30, d, t);
        check("id_manuf", d, 16'h0089);
        bus_read(8'h31, d, t);
        check("id_device", d, 16'h8960);
        bus_read(8'h32, d, t);
        check("id_other", d, 16'h0000);
        host_write(8'h00, 16'h00FF, "read_array_cmd", bs);
        bus_read(8'h10, d, t);
        check("array_after_id", d, 16'h1234);

        // Randomized command mix against the model
        for (int k = 0; k < 60; k++) begin
            op = int'($urandom_range(0, 4));
            ra = AW'($urandom_range(0, WORDS - 1));
            case (op)
                0: host_read(ra, "rnd_read");
                1: begin
                    host_write(ra, ($urandom_range(0, 1) != 0) ? 16'h0040 : 16'h0010, "rnd_psetup", bs);
                    host_write(ra, 16'($urandom), "rnd_pdata", bs);
                    host_read(AW'($urandom_range(0, WORDS - 1)), "rnd_pread");
                end
                2: begin
                    host_write(ra, 16'h0020, "rnd_esetup", bs);
                    host_write(ra, 16'h00D0, "rnd_econfirm", bs);
                end
                3: begin
                    case ($urandom_range(0, 4))
                        0:       d = 16'h00FF;
                        1:       d = 16'h0070;
                        2:       d = 16'h0090;
                        3:       d = 16'h0050;
                        default: d = 16'h0033;
                    endcase
                    host_write(ra, d, "rnd_cmd", bs);
                    host_read(AW'($urandom_range(0, WORDS - 1)), "rnd_cread");
                end
                default: begin
                    host_write(ra, 16'h0020, "rnd_xsetup", bs);
                    host_write(ra, ($urandom_range(0, 1) != 0) ? 16'h0070 : 16'h0040, "rnd_xbad", bs);
                    host_read(ra, "rnd_xstatus");
                end
            endcase
        end

        bad = 0;
        for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_vs_model", bad, 0);

        // Reset in the middle of an erase
        host_write(8'h80, 16'h0020, "rst_erase_setup", bs);
        bus_write(8'h85, 16'h00D0);
        check("rst_erase_running", mem_we, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_erase_we_drop", mem_we, 1'b0);
        check("rst_erase_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
